// File: rtl/life_field_reader_if.sv
// Row-streaming bus between the Game-of-Life field reader and its requester.
// master: drives field/start/row_ready; slave: the reader itself.
interface life_field_reader_if #(
  parameter int SIZE = 10
);
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int POP_W = $clog2(SIZE * SIZE + 1);

  logic [SIZE*SIZE-1:0] field;
  logic                 start;
  logic                 busy;
  logic                 row_valid;
  logic                 row_ready;
  logic [SIZE-1:0]      row_data;
  logic [IDX_W-1:0]     row_index;
  logic                 done;
  logic [POP_W-1:0]     population;

  modport master (
    output field, start, row_ready,
    input  busy, row_valid, row_data, row_index, done, population
  );

  modport slave (
    input  field, start, row_ready,
    output busy, row_valid, row_data, row_index, done, population
  );
endinterface

// File: rtl/life_field_reader.sv
// Snapshots the life field on start and streams it out one row per valid/ready
// transfer, reporting the live-cell population once the last row is accepted.
module life_field_reader #(
  parameter int SIZE = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  life_field_reader_if.slave bus
);
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int POP_W = $clog2(SIZE * SIZE + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]           r_state;
  logic [SIZE*SIZE-1:0] r_snapshot;
  logic [SIZE-1:0]      r_row_data;
  logic [IDX_W-1:0]     r_row_index;
  logic [POP_W-1:0]     r_acc;
  logic [POP_W-1:0]     r_population;
  logic                 r_done;

  logic                 w_send;
  logic                 w_last;
  logic [IDX_W-1:0]     w_next_index;
  logic [SIZE*SIZE-1:0] w_shifted;
  logic [POP_W-1:0]     w_row_pop;
  logic [POP_W-1:0]     w_sum;

  assign w_send       = (r_state == ST_SEND);
  assign w_last       = (r_row_index == IDX_W'(SIZE - 1));
  assign w_next_index = r_row_index + IDX_W'(1);
  // Rows are read from the snapshot only, so the core may step mid-scan.
  assign w_shifted    = r_snapshot >> (SIZE * int'(w_next_index));
  assign w_sum        = r_acc + w_row_pop;

  always_comb begin
    w_row_pop = '0;
    for (int i = 0; i < SIZE; i++) begin
      w_row_pop = w_row_pop + POP_W'(r_row_data[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_snapshot   <= '0;
      r_row_data   <= '0;
      r_row_index  <= '0;
      r_acc        <= '0;
      r_population <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state     <= ST_SEND;
            r_snapshot  <= bus.field;
            r_row_index <= '0;
            r_row_data  <= bus.field[SIZE-1:0];
            r_acc       <= '0;
          end
        end
        ST_SEND: begin
          // row_valid is always high in SEND, so ready alone completes a transfer.
          if (bus.row_ready) begin
            r_acc <= w_sum;
            if (w_last) begin
              r_state      <= ST_IDLE;
              r_population <= w_sum;
              r_done       <= 1'b1;
            end else begin
              r_row_index <= w_next_index;
              r_row_data  <= w_shifted[SIZE-1:0];
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = w_send;
  assign bus.row_valid  = w_send;
  assign bus.row_data   = r_row_data;
  assign bus.row_index  = r_row_index;
  assign bus.done       = r_done;
  assign bus.population = r_population;
endmodule

// File: tb/tb_life_field_reader.sv
// Self-checking bench for life_field_reader: scenario tasks compare observed
// row streams, done timing and population against a field-level model.
module tb_life_field_reader;
  localparam int SIZE  = 10;
  localparam int N     = SIZE * SIZE;
  localparam int POP_W = 7;
  localparam int MAXC  = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  life_field_reader_if #(.SIZE(SIZE)) bus ();
  life_field_reader #(.SIZE(SIZE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  // scan configuration
  int         cfg_rmode;
  int         cfg_change_row;
  logic [N-1:0] cfg_f_after;
  bit         cfg_hold_start;
  int         cfg_pulse_cyc;

  // observations collected by run_scan
  logic [SIZE-1:0] obs_data[$];
  int              obs_idx[$];
  bit              rdy_hist[$];
  int              done_cnt, done_cyc, hold_err, pop_changed, timed_out;
  logic [POP_W-1:0] pop_at_done;
  int              exp_pop;

  function automatic logic [SIZE-1:0] model_row(input logic [N-1:0] f, input int y);
    logic [SIZE-1:0] r;
    for (int x = 0; x < SIZE; x++) r[x] = f[y*SIZE + x];
    return r;
  endfunction

  function automatic int model_pop(input logic [N-1:0] f);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(f[i]);
    return c;
  endfunction

  // rows are offered continuously from cycle 1, so the 10th ready cycle is the last transfer
  function automatic int model_done_cycle();
    int cnt = 0;
    for (int c = 1; c <= rdy_hist.size(); c++) begin
      if (rdy_hist[c-1]) cnt++;
      if (cnt == SIZE) return c + 1;
    end
    return -1;
  endfunction

  function automatic bit ready_for(input int c);
    if (cfg_rmode == 1) return ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
    if (cfg_rmode == 2) return $urandom_range(0, 3) != 0;
    return 1'b1;
  endfunction

  function automatic logic [N-1:0] rand_field(input int density);
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = ($urandom_range(0, 99) < density);
    return f;
  endfunction

  task automatic cfg_default();
    cfg_rmode = 0; cfg_change_row = -1; cfg_f_after = '0;
    cfg_hold_start = 1'b0; cfg_pulse_cyc = -1;
  endtask

  task automatic run_scan(input logic [N-1:0] f);
    logic [SIZE-1:0] prev_data;
    int  prev_idx;
    bit  pending, accepted, r;
    obs_data.delete(); obs_idx.delete(); rdy_hist.delete();
    done_cnt = 0; done_cyc = -1; hold_err = 0; pop_changed = 0; timed_out = 0;
    pending = 0; prev_data = '0; prev_idx = 0;
    bus.field = f;
    bus.start = 1'b1;
    r = ready_for(1); bus.row_ready = r; rdy_hist.push_back(r);
    @(posedge clk); #1;
    bus.start = cfg_hold_start || (cfg_pulse_cyc == 1);
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; pop_at_done = bus.population; end
      end else if (bus.population !== POP_W'(exp_pop)) pop_changed++;
      if (pending && (bus.row_valid !== 1'b1 || bus.row_data !== prev_data ||
                      int'(bus.row_index) != prev_idx)) hold_err++;
      accepted = (bus.row_valid === 1'b1) && rdy_hist[c-1];
      if (accepted) begin
        obs_data.push_back(bus.row_data);
        obs_idx.push_back(int'(bus.row_index));
      end
      pending   = (bus.row_valid === 1'b1) && !rdy_hist[c-1];
      prev_data = bus.row_data;
      prev_idx  = int'(bus.row_index);
      if (done_cyc >= 0) break;
      @(posedge clk); #1;
      if (accepted && obs_idx[$] == cfg_change_row) bus.field = cfg_f_after;
      bus.start = cfg_hold_start || (c + 1 == cfg_pulse_cyc);
      r = ready_for(c + 1); bus.row_ready = r; rdy_hist.push_back(r);
    end
    if (done_cyc < 0) timed_out = 1;
  endtask

  task automatic test_reset();
    bus.field = '1; bus.start = 1'b0; bus.row_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.row_valid, bus.row_data, bus.row_index, bus.done, bus.population} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b valid=%b data=%h idx=%0d done=%b pop=%0d required all 0",
               bus.busy, bus.row_valid, bus.row_data, bus.row_index, bus.done, bus.population);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.row_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle: got busy=%b valid=%b required 0 0", bus.busy, bus.row_valid);
    end
    exp_pop = 0;
  endtask

  task automatic test_glider();
    logic [N-1:0] f = '0;
    logic [SIZE-1:0] spec_rows [3];
    f[1] = 1'b1; f[12] = 1'b1; f[20] = 1'b1; f[21] = 1'b1; f[22] = 1'b1;
    spec_rows[0] = 10'h002; spec_rows[1] = 10'h004; spec_rows[2] = 10'h007;
    cfg_default();
    run_scan(f);
    total++;
    if (timed_out != 0 || obs_data.size() != SIZE) begin
      bad++; $display("FAIL glider_rows: got %0d rows timeout=%0d required %0d rows", obs_data.size(), timed_out, SIZE);
    end
    for (int i = 0; i < obs_data.size() && i < SIZE; i++) begin
      total++;
      if (obs_idx[i] != i || obs_data[i] !== model_row(f, i) ||
          (i < 3 && obs_data[i] !== spec_rows[i]) || (i >= 3 && obs_data[i] !== '0)) begin
        bad++; $display("FAIL glider_row%0d: got idx=%0d data=%h required idx=%0d data=%h",
                        i, obs_idx[i], obs_data[i], i, model_row(f, i));
      end
    end
    total++;
    if (done_cyc != SIZE + 1 || done_cyc != model_done_cycle() || hold_err != 0) begin
      bad++; $display("FAIL glider_done_cycle: got %0d (hold_err=%0d) required %0d", done_cyc, hold_err, SIZE + 1);
    end
    total++;
    if (pop_at_done !== POP_W'(5) || pop_changed != 0) begin
      bad++; $display("FAIL glider_population: got %0d (early changes=%0d) required 5", pop_at_done, pop_changed);
    end
    exp_pop = model_pop(f);
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.row_valid !== 1'b0) begin
      bad++; $display("FAIL glider_done_pulse: got done=%b busy=%b valid=%b after pulse required 0 0 0",
                      bus.done, bus.busy, bus.row_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] f = '0;
    f[1] = 1'b1; f[12] = 1'b1; f[20] = 1'b1; f[21] = 1'b1; f[22] = 1'b1;
    cfg_default(); cfg_rmode = 1;
    run_scan(f);
    total++;
    if (timed_out != 0 || obs_data.size() != SIZE || hold_err != 0) begin
      bad++; $display("FAIL bp_stream: got rows=%0d hold_err=%0d timeout=%0d required %0d 0 0",
                      obs_data.size(), hold_err, timed_out, SIZE);
    end
    for (int i = 0; i < obs_data.size() && i < SIZE; i++) begin
      total++;
      if (obs_idx[i] != i || obs_data[i] !== model_row(f, i)) begin
        bad++; $display("FAIL bp_row%0d: got idx=%0d data=%h required idx=%0d data=%h",
                        i, obs_idx[i], obs_data[i], i, model_row(f, i));
      end
    end
    total++;
    if (done_cyc != model_done_cycle() || done_cyc != 21) begin
      bad++; $display("FAIL bp_done_cycle: got %0d required %0d", done_cyc, model_done_cycle());
    end
    total++;
    if (pop_at_done !== POP_W'(model_pop(f)) || pop_changed != 0) begin
      bad++; $display("FAIL bp_population: got %0d required %0d", pop_at_done, model_pop(f));
    end
    exp_pop = model_pop(f);
  endtask

  task automatic test_snapshot();
    logic [N-1:0] f = '1;
    int row_err = 0;
    cfg_default(); cfg_change_row = 2; cfg_f_after = '0;
    run_scan(f);
    for (int i = 0; i < obs_data.size(); i++)
      if (obs_data[i] !== 10'h3FF || obs_idx[i] != i) row_err++;
    total++;
    if (obs_data.size() != SIZE || row_err != 0 || timed_out != 0) begin
      bad++; $display("FAIL snapshot_rows: got rows=%0d wrong=%0d required %0d rows of 3ff",
                      obs_data.size(), row_err, SIZE);
    end
    total++;
    if (pop_at_done !== POP_W'(100) || pop_changed != 0) begin
      bad++; $display("FAIL snapshot_population: got %0d required 100", pop_at_done);
    end
    exp_pop = 100;
  endtask

  task automatic test_start_collision();
    logic [N-1:0] f1, f2, f3;
    int rows, row_err, dcnt, pop_err;
    logic [POP_W-1:0] pop2;
    f1 = rand_field(40); f2 = rand_field(60);
    cfg_default(); cfg_hold_start = 1'b1; cfg_change_row = 5; cfg_f_after = f2;
    run_scan(f1);
    row_err = 0;
    for (int i = 0; i < obs_data.size(); i++)
      if (obs_data[i] !== model_row(f1, i) || obs_idx[i] != i) row_err++;
    total++;
    if (obs_data.size() != SIZE || row_err != 0 || done_cyc != SIZE + 1 || pop_at_done !== POP_W'(model_pop(f1))) begin
      bad++; $display("FAIL hold_first_scan: got rows=%0d wrong=%0d done=%0d pop=%0d required %0d 0 %0d %0d",
                      obs_data.size(), row_err, done_cyc, pop_at_done, SIZE, SIZE + 1, model_pop(f1));
    end
    exp_pop = model_pop(f1);
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if (bus.row_valid !== 1'b1 || bus.row_index !== 4'd0 || bus.row_data !== model_row(f2, 0) || bus.done !== 1'b0) begin
      bad++; $display("FAIL hold_second_start: got valid=%b idx=%0d data=%h done=%b required 1 0 %h 0",
                      bus.row_valid, bus.row_index, bus.row_data, bus.done, model_row(f2, 0));
    end
    rows = 0; row_err = 0; dcnt = 0; pop_err = 0; pop2 = '0;
    for (int c = 0; c < 30 && dcnt == 0; c++) begin
      if (bus.done === 1'b1) begin dcnt++; pop2 = bus.population; end
      else if (bus.population !== POP_W'(exp_pop)) pop_err++;
      if (bus.row_valid === 1'b1) begin
        if (bus.row_data !== model_row(f2, rows) || int'(bus.row_index) != rows) row_err++;
        rows++;
      end
      @(negedge clk);
    end
    total++;
    if (rows != SIZE || row_err != 0 || dcnt != 1 || pop_err != 0 || pop2 !== POP_W'(model_pop(f2))) begin
      bad++; $display("FAIL hold_second_scan: got rows=%0d wrong=%0d done=%0d pop_err=%0d pop=%0d required %0d 0 1 0 %0d",
                      rows, row_err, dcnt, pop_err, pop2, SIZE, model_pop(f2));
    end
    exp_pop = model_pop(f2);

    f3 = rand_field(30);
    cfg_default(); cfg_pulse_cyc = 4;
    run_scan(f3);
    total++;
    if (obs_data.size() != SIZE || done_cyc != SIZE + 1 || pop_at_done !== POP_W'(model_pop(f3))) begin
      bad++; $display("FAIL midpulse_scan: got rows=%0d done=%0d pop=%0d required %0d %0d %0d",
                      obs_data.size(), done_cyc, pop_at_done, SIZE, SIZE + 1, model_pop(f3));
    end
    exp_pop = model_pop(f3);
    dcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) dcnt++;
    end
    total++;
    if (dcnt != 0) begin
      bad++; $display("FAIL midpulse_extra_scan: got %0d busy/done cycles after scan required 0", dcnt);
    end
  endtask

  task automatic test_reset_midscan();
    logic [N-1:0] f = rand_field(50);
    int found = 0;
    int dcnt = 0;
    cfg_default();
    bus.field = f; bus.start = 1'b1; bus.row_ready = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcnt++;
      if (bus.row_valid === 1'b1 && bus.row_index === 4'd5) found = 1;
    end
    total++;
    if (found == 0) begin
      bad++; $display("FAIL midreset_reach_row5: got no row 5 within 20 cycles required row 5");
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.row_valid, bus.row_data, bus.row_index, bus.done, bus.population} !== '0) begin
      bad++; $display("FAIL midreset_outputs: got busy=%b valid=%b data=%h idx=%0d done=%b pop=%0d required all 0",
                      bus.busy, bus.row_valid, bus.row_data, bus.row_index, bus.done, bus.population);
    end
    repeat (2) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcnt++;
    end
    rst_n = 1'b1;
    exp_pop = 0;
    @(negedge clk);
    if (bus.done === 1'b1) dcnt++;
    total++;
    if (dcnt != 0 || bus.busy !== 1'b0 || bus.population !== '0) begin
      bad++; $display("FAIL midreset_no_done: got done_pulses=%0d busy=%b pop=%0d required 0 0 0",
                      dcnt, bus.busy, bus.population);
    end
    f = rand_field(50);
    run_scan(f);
    total++;
    if (obs_data.size() != SIZE || done_cyc != SIZE + 1 || pop_at_done !== POP_W'(model_pop(f)) || pop_changed != 0) begin
      bad++; $display("FAIL midreset_rescan: got rows=%0d done=%0d pop=%0d required %0d %0d %0d",
                      obs_data.size(), done_cyc, pop_at_done, SIZE, SIZE + 1, model_pop(f));
    end
    exp_pop = model_pop(f);
  endtask

  task automatic test_random();
    logic [N-1:0] f;
    int row_err;
    for (int it = 0; it < 6; it++) begin
      f = rand_field($urandom_range(0, 100));
      cfg_default(); cfg_rmode = 2;
      if (it % 2 == 1) begin cfg_change_row = $urandom_range(0, SIZE - 1); cfg_f_after = rand_field(50); end
      run_scan(f);
      row_err = 0;
      for (int i = 0; i < obs_data.size(); i++)
        if (obs_data[i] !== model_row(f, i) || obs_idx[i] != i) row_err++;
      total++;
      if (obs_data.size() != SIZE || row_err != 0 || hold_err != 0 || done_cnt != 1 ||
          done_cyc != model_done_cycle() || pop_at_done !== POP_W'(model_pop(f)) || pop_changed != 0) begin
        bad++; $display("FAIL random_scan%0d: got rows=%0d wrong=%0d hold=%0d done@%0d pop=%0d required %0d 0 0 done@%0d pop=%0d",
                        it, obs_data.size(), row_err, hold_err, done_cyc, pop_at_done,
                        SIZE, model_done_cycle(), model_pop(f));
      end
      exp_pop = model_pop(f);
    end
  endtask

  initial begin
    exp_pop = 0;
    cfg_default();
    test_reset();
    test_glider();
    test_backpressure();
    test_snapshot();
    test_start_collision();
    test_reset_midscan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/life_field_reader.md
Name: life_field_reader

Overview:
- Reads the SIZE×SIZE Game-of-Life field vector produced by the life core and streams it out one row per transfer over a valid/ready interface.
- Snapshots the field when a scan starts, so a core stepping mid-scan cannot tear the frame.
- Reports the live-cell population of each completed scan.
- Sits between the life core's field output and downstream consumers (serial link, display driver, logger).

Parameters:
- SIZE, 10, field edge length. Field is SIZE*SIZE bits; cell (x,y) is bit y*SIZE+x.
- IDX_W, max(1,$clog2(SIZE)), width of row_index (derived, not overridden).
- POP_W, $clog2(SIZE*SIZE+1), width of population (derived; 7 for SIZE=10).

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- field  input  SIZE*SIZE  current field from the life core.
- start  input  1  request a scan; sampled only in IDLE.
- busy  output  1  high while a scan is in progress.
- row_valid  output  1  row_data/row_index hold a row offered downstream.
- row_ready  input  1  downstream accepts the row when high together with row_valid.
- row_data  output  SIZE  snapshot row; bit x = cell (x,row_index).
- row_index  output  IDX_W  row number 0..SIZE-1.
- done  output  1  one-cycle pulse after the last row is accepted.
- population  output  POP_W  live-cell count of the last completed scan.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0 (busy, row_valid, row_data, row_index, done, population); snapshot and accumulator cleared. Takes effect immediately and aborts any scan; no done pulse.
- States:
  - IDLE: row_valid=0, busy=0.
  - SEND: busy=1, row_valid=1.
- IDLE→SEND on posedge with start=1:
  - snapshot <= field;
  - row_index <= 0; row_data <= field[SIZE-1:0]; accumulator <= 0.
  - Row 0 is valid the cycle after start is sampled.
- SEND, handshake (row_valid && row_ready):
  - accumulator += popcount(row_data), saturation impossible at POP_W.
  - If row_index < SIZE-1: row_index++; row_data <= next snapshot row in the next cycle. Back-to-back transfers give one row per cycle.
  - If row_index == SIZE-1: next state IDLE; population <= final sum; done=1 for exactly one cycle; row_valid=0; busy=0.
- SEND without handshake: row_data and row_index held stable. Standard valid/ready rule: valid never drops before acceptance.
- Latency with row_ready tied high: start sampled at edge 0 → rows on cycles 1..SIZE → done on cycle SIZE+1.
- start while in SEND: ignored; no queuing.
- start in the cycle done is high: accepted (FSM is already IDLE); new scan begins normally; population keeps the previous result until the new scan completes.
- field changes during SEND: no effect on the rows streamed; only the snapshot is output.
- population changes only on scan completion or reset.
- row_data after the final transfer: don't care while row_valid=0.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → all outputs 0 immediately; release → IDLE, busy=0.
- Glider, SIZE=10, row_ready=1: field bits 1, 12, 20, 21, 22 set; pulse start → rows 0..9 on consecutive cycles; row0=0x002, row1=0x004, row2=0x007, rest 0x000; done on cycle 11; population=5.
- Backpressure: same field; row_ready = 1,0,0,1 repeating → each row held stable while row_ready=0; no row skipped or duplicated; done after the 10th acceptance; population=5.
- Snapshot isolation: start a scan on all-ones field, set field to 0 after row 2 is accepted → every row reads 0x3FF; population=100.
- Start collisions:
  - start held high through a scan → exactly one scan, then a second scan starting the cycle done pulses;
  - start pulsed mid-scan only → ignored, single done.
- Reset mid-scan: drop rst_n during row 5 → row_valid=0, busy=0, no done, population retains 0 (cleared); next start runs a full scan.
